// File: rtl/mmio_responder.sv
// Data-memory front end: passes RAM traffic to the dmem syncram and decodes the top
// 256 words into LED, free-running timer/compare, status and RX byte FIFO registers.
module mmio_responder (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [11:0] ram_address,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] leds,
    output logic        timer_irq
);

    localparam logic [11:0] AddrLed     = 12'hF00;
    localparam logic [11:0] AddrCount   = 12'hF01;
    localparam logic [11:0] AddrCompare = 12'hF02;
    localparam logic [11:0] AddrStatus  = 12'hF03;
    localparam logic [11:0] AddrRxPop   = 12'hF04;
    localparam logic [11:0] AddrIrqAck  = 12'hF05;

    logic [15:0] leds_q;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q;
    logic        pending_q, pending_d;
    logic [7:0]  fifo_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  fifo_cnt_q, fifo_cnt_d;
    logic        sel_ram_q;
    logic [31:0] mmio_q;

    logic        in_ram;
    logic        fifo_full, fifo_empty;
    logic        push, pop;
    logic [31:0] status;
    logic [31:0] mmio_rdata;

    assign in_ram      = address_dmem < AddrLed;
    assign ram_address = address_dmem;
    assign ram_data    = data;
    assign ram_wren    = wren && in_ram;

    assign fifo_full  = fifo_cnt_q == 3'd4;
    assign fifo_empty = fifo_cnt_q == 3'd0;
    assign rx_ready   = reset && !fifo_full;
    assign push       = rx_valid && rx_ready;
    assign pop        = !wren && (address_dmem == AddrRxPop) && !fifo_empty;

    assign status = {26'b0, fifo_cnt_q, pending_q, fifo_full, !fifo_empty};

    // Read mux sees pre-edge register values, so a same-edge store is not visible.
    always_comb begin
        mmio_rdata = 32'b0;
        case (address_dmem)
            AddrLed:     mmio_rdata = {16'b0, leds_q};
            AddrCount:   mmio_rdata = count_q;
            AddrCompare: mmio_rdata = compare_q;
            AddrStatus:  mmio_rdata = status;
            AddrRxPop:   mmio_rdata = fifo_empty ? 32'b0 : {24'b0, fifo_q[rd_ptr_q]};
            default:     mmio_rdata = 32'b0;
        endcase
    end

    always_comb begin
        count_d = count_q + 32'd1;
        if (wren && address_dmem == AddrCount) begin
            count_d = 32'b0;
        end
    end

    // A match on the same edge as an ack keeps the flag set.
    always_comb begin
        pending_d = pending_q;
        if (wren && address_dmem == AddrIrqAck) begin
            pending_d = 1'b0;
        end
        if (count_q == compare_q && compare_q != 32'b0) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            leds_q    <= 16'b0;
            count_q   <= 32'b0;
            compare_q <= 32'b0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            if (wren && address_dmem == AddrLed) begin
                leds_q <= data[15:0];
            end
            if (wren && address_dmem == AddrCompare) begin
                compare_q <= data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= 8'b0;
            end
            wr_ptr_q   <= 2'b0;
            rd_ptr_q   <= 2'b0;
            fifo_cnt_q <= 3'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= rx_data;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_ram_q <= 1'b1;
            mmio_q    <= 32'b0;
        end else begin
            sel_ram_q <= in_ram;
            mmio_q    <= mmio_rdata;
        end
    end

    assign q_dmem    = sel_ram_q ? ram_q : mmio_q;
    assign leds      = leds_q;
    assign timer_irq = pending_q;

endmodule
